job_dispatcher: RTL and testbench
=================================

JOB_DISPATCHER -- requirements
Module: job_dispatcher

Interface
REQ-001 Parameter DEPTH, default 16, operand FIFO depth in entries; power of two, 2..128.
REQ-002 Parameter TIMEOUT, default 64, maximum cycles from last data beat to finish before the job is aborted.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  producer offers an operand entry.
REQ-006 in_ready  output  1  FIFO can accept; push = in_valid & in_ready.
REQ-007 in_A, in_B  input  8 each  operands.
REQ-008 in_op  input  4  ALU instruction code.
REQ-009 launch  input  1  request to dispatch all entries currently queued as one job.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 start  output  1  job-start pulse to the third-largest engine.
REQ-013 count  output  8  job length presented with start.
REQ-014 valid  output  1  data beat qualifier to engine.
REQ-015 data_A, data_B  output  8 each; instruction  output  4 -- beat payload.
REQ-016 finish  input  1  one-cycle completion pulse from engine.
REQ-017 third_largest  input  8  engine result, valid in finish cycle.
REQ-018 res_valid  output  1; res_ready  input  1 -- result handshake.
REQ-019 res_data  output  8  captured result; res_err  output  1  high = job timed out.

Function
REQ-020 FIFO SHALL store {in_A,in_B,in_op} in order; in_ready = (level < DEPTH), registered-level based, independent of a same-cycle pop.
REQ-021 Push and pop in the same cycle SHALL leave level unchanged; pointers SHALL wrap modulo DEPTH.
REQ-022 FSM states SHALL be IDLE, START, STREAM, WAIT, RESULT.
REQ-023 IDLE: launch with level = 0 SHALL be ignored; launch with level > 0 SHALL snapshot N = level into a job counter and go to START.
REQ-024 START (exactly one cycle): start = 1, count = N; all other cycles start = 0 and count = last N.
REQ-025 STREAM SHALL follow START and drive valid = 1 with FIFO head payload for N consecutive cycles, popping one entry per cycle; then go to WAIT.
REQ-026 Entries pushed after the launch snapshot SHALL NOT join the current job; they remain queued.
REQ-027 valid SHALL be 0 and data_A/data_B/instruction SHALL be 0 outside STREAM.
REQ-028 WAIT: finish = 1 SHALL capture third_largest into res_data, clear res_err, go to RESULT; a timeout counter SHALL count WAIT cycles and, on reaching TIMEOUT without finish, set res_data = 0, res_err = 1, go to RESULT.
REQ-029 finish seen outside WAIT SHALL be ignored.
REQ-030 RESULT: res_valid = 1 with res_data/res_err stable until res_ready = 1; on that cycle go to IDLE (next launch accepted the cycle after).
REQ-031 launch outside IDLE SHALL be ignored, not queued.
REQ-032 Job latency launch -> first valid beat SHALL be 2 cycles (launch edge -> START cycle -> STREAM cycle).

Reset
REQ-033 rst SHALL immediately clear FIFO (level 0, pointers 0), state IDLE, start/valid/res_valid/res_err/busy 0, count/res_data/data outputs 0, in_ready 1.
REQ-034 rst mid-job SHALL discard the job and all queued entries; no result is produced.

Verification
REQ-035 Push 5 entries (op=ADD, A=1..5, B=10) then launch -> start one cycle with count=5, next 5 cycles valid with A=1..5, engine model finishes -> res_data=13, res_err=0.
REQ-036 Push 16 entries with in_valid held -> in_ready drops when level=16; 17th offer not accepted; level stays 16.
REQ-037 Launch with 3 queued, push 2 more during STREAM -> count=3, exactly 3 beats; fifo_level=2 after job; second launch gives count=2.
REQ-038 Engine never pulses finish -> after TIMEOUT=64 WAIT cycles res_valid=1, res_err=1, res_data=0.
REQ-039 Hold res_ready=0 for 10 cycles in RESULT -> res_valid/res_data stable; launch ignored; res_ready=1 -> IDLE next cycle.
REQ-040 Assert rst during STREAM beat 2 of 8 -> valid=0, level=0, busy=0 immediately; no res_valid afterward.

Source files
------------

// File: rtl/job_dispatcher.sv
// Job dispatcher: queues ALU operand entries, streams a launched batch to the
// third-largest engine, then collects its result (or a timeout) for the consumer.
module job_dispatcher #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_A,
  input  logic [7:0]               in_B,
  input  logic [3:0]               in_op,
  input  logic                     launch,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     start,
  output logic [7:0]               count,
  output logic                     valid,
  output logic [7:0]               data_A,
  output logic [7:0]               data_B,
  output logic [3:0]               instruction,
  input  logic                     finish,
  input  logic [7:0]               third_largest,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [7:0]               res_data,
  output logic                     res_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_RESULT
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } entry_t;

  state_t          r_state;
  state_t          w_state_nxt;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [LW-1:0]   r_job_left;
  logic [7:0]      r_count;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_res_data;
  logic            r_res_err;

  logic            w_push;
  logic            w_pop;
  logic            w_launch_ok;
  logic            w_tmo_hit;
  entry_t          w_head;

  // in_ready looks only at the registered level, so a full FIFO refuses a push
  // even in a cycle where STREAM is popping.
  assign in_ready    = (r_level < LW'(DEPTH));
  assign w_push      = in_valid & in_ready;
  assign w_pop       = (r_state == S_STREAM);
  assign w_launch_ok = launch && (r_level != '0);
  assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; only pointers and level define what is
  // valid, and data outputs are gated by STREAM, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{a: in_A, b: in_B, op: in_op};
    end
  end

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: next-state takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (w_launch_ok)              w_state_nxt = S_START;
      S_START:                                w_state_nxt = S_STREAM;
      S_STREAM: if (r_job_left == LW'(1))     w_state_nxt = S_WAIT;
      S_WAIT:   if (finish || w_tmo_hit)      w_state_nxt = S_RESULT;
      S_RESULT: if (res_ready)                w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // Job length is frozen at launch; later pushes only raise the FIFO level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_job_left <= '0;
      r_tmo      <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_launch_ok) begin
        r_count    <= 8'(r_level);
        r_job_left <= r_level;
      end
      if (w_pop) begin
        r_job_left <= r_job_left - 1'b1;
      end

      if (r_state == S_WAIT && !finish) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end

      if (r_state == S_WAIT) begin
        if (finish) begin
          r_res_data <= third_largest;
          r_res_err  <= 1'b0;
        end else if (w_tmo_hit) begin
          r_res_data <= '0;
          r_res_err  <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign start       = (r_state == S_START);
  assign valid       = (r_state == S_STREAM);
  assign data_A      = valid ? w_head.a  : '0;
  assign data_B      = valid ? w_head.b  : '0;
  assign instruction = valid ? w_head.op : '0;
  assign count       = r_count;
  assign fifo_level  = r_level;
  assign res_valid   = (r_state == S_RESULT);
  assign res_data    = r_res_data;
  assign res_err     = r_res_err;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    r_level <= LW'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    w_pop |-> (r_level != '0));

endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench for job_dispatcher: directed job table, hand-written corner
// sequences and randomized jobs scored against a queue-based reference model.
module tb_job_dispatcher;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_A;
  logic [7:0]             in_B;
  logic [3:0]             in_op;
  logic                   launch;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   start;
  logic [7:0]             count;
  logic                   valid;
  logic [7:0]             data_A;
  logic [7:0]             data_B;
  logic [3:0]             instruction;
  logic                   finish;
  logic [7:0]             third_largest;
  logic                   res_valid;
  logic                   res_ready;
  logic [7:0]             res_data;
  logic                   res_err;

  job_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_op(in_op),
    .launch(launch), .busy(busy), .fifo_level(fifo_level),
    .start(start), .count(count), .valid(valid),
    .data_A(data_A), .data_B(data_B), .instruction(instruction),
    .finish(finish), .third_largest(third_largest),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } entry_t;

  typedef struct {
    int         n;
    logic [3:0] op;
    logic [7:0] a0;
    logic [7:0] b;
    int         fin_delay;
    int         rdy_delay;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  entry_t model_q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Engine convention: third-largest of the beat results, 0 when fewer than three beats.
  function automatic logic [7:0] third_of(input logic [7:0] vals[$]);
    logic [7:0] s[$];
    s = vals;
    s.rsort();
    if (s.size() < 3) return 8'h00;
    return s[2];
  endfunction

  // One clock: record an accepted push in the model, then check level/ready.
  task automatic tick();
    logic   pushed;
    entry_t e;
    pushed = in_valid && in_ready;
    e = '{a: in_A, b: in_B, op: in_op};
    @(posedge clk);
    if (pushed) model_q.push_back(e);
    @(negedge clk);
    check("fifo_level", 32'(fifo_level), 32'(model_q.size()));
    check("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
  endtask

  task automatic push_seq(input int n, input logic [3:0] op, input logic [7:0] a0, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_A     = a0 + 8'(i);
      in_B     = b;
      in_op    = op;
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Launch a job from IDLE and play engine + consumer around it.
  task automatic run_job(input int fin_delay, input int rdy_delay, input int extra_push,
                         input bit noise, output logic [7:0] got_res, output logic got_err,
                         output int got_count);
    int         exp_n;
    int         w;
    bit         got;
    bit         exp_err;
    logic [7:0] exp_res;
    logic [7:0] eng_tl;
    logic [7:0] mdl_vals[$];
    logic [7:0] eng_vals[$];
    entry_t     e;

    exp_n  = model_q.size();
    launch = 1'b1;
    tick();
    launch = 1'b0;
    check("start_pulse", 32'(start), 32'(1));
    check("start_count", 32'(count), 32'(exp_n));
    check("start_busy", 32'(busy), 32'(1));
    check("start_valid_low", 32'(valid), 32'(0));
    got_count = int'(count);
    tick();

    for (int i = 0; i < exp_n; i++) begin
      e = model_q.pop_front();
      check("beat_valid", 32'(valid), 32'(1));
      check("beat_start_low", 32'(start), 32'(0));
      check("beat_A", 32'(data_A), 32'(e.a));
      check("beat_B", 32'(data_B), 32'(e.b));
      check("beat_op", 32'(instruction), 32'(e.op));
      mdl_vals.push_back(alu(e.op, e.a, e.b));
      eng_vals.push_back(alu(instruction, data_A, data_B));
      if (i < extra_push) begin
        in_valid = 1'b1;
        in_A     = 8'($urandom);
        in_B     = 8'($urandom);
        in_op    = 4'($urandom_range(0, 4));
      end
      if (noise) begin
        finish        = ($urandom_range(0, 2) == 0);
        third_largest = 8'($urandom);
      end
      tick();
      in_valid      = 1'b0;
      finish        = 1'b0;
      third_largest = 8'h00;
    end

    eng_tl  = third_of(eng_vals);
    exp_err = (fin_delay >= TIMEOUT);
    exp_res = exp_err ? 8'h00 : third_of(mdl_vals);
    w   = 0;
    got = 1'b0;
    for (int c = 0; c < TIMEOUT + 10; c++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      check("wait_valid_low", 32'(valid), 32'(0));
      check("wait_data_zero", 32'({data_A, data_B, instruction}), 32'(0));
      check("wait_count_held", 32'(count), 32'(exp_n));
      if (w == fin_delay) begin
        finish        = 1'b1;
        third_largest = eng_tl;
      end
      tick();
      finish        = 1'b0;
      third_largest = 8'h00;
      w++;
    end
    check("result_seen", 32'(got), 32'(1));
    check("wait_cycles", 32'(w), 32'(exp_err ? TIMEOUT : fin_delay + 1));
    check("res_data", 32'(res_data), 32'(exp_res));
    check("res_err", 32'(res_err), 32'(exp_err));
    got_res = res_data;
    got_err = res_err;

    for (int r = 0; r < rdy_delay; r++) begin
      launch = 1'b1;
      tick();
      check("hold_res_valid", 32'(res_valid), 32'(1));
      check("hold_res_data", 32'(res_data), 32'(got_res));
      check("hold_res_err", 32'(res_err), 32'(got_err));
      check("hold_no_start", 32'(start), 32'(0));
    end
    launch    = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_res_valid", 32'(res_valid), 32'(0));
    check("idle_count_held", 32'(count), 32'(exp_n));
  endtask

  vec_t       vecs[5];
  logic [7:0] r_res;
  logic       r_err;
  int         r_cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not terminate");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // {n, op, a0, b, finish delay, ready delay, expected res_data, expected res_err}
    vecs[0] = '{5, 4'd0, 8'd1,  8'd10,   3,  0, 8'd13,  1'b0};
    vecs[1] = '{3, 4'd1, 8'd20, 8'd5,    0,  2, 8'd15,  1'b0};
    vecs[2] = '{4, 4'd4, 8'd0,  8'hF0,  63,  1, 8'hF1,  1'b0};
    vecs[3] = '{2, 4'd0, 8'd1,  8'd1,    5,  0, 8'd0,   1'b0};
    vecs[4] = '{6, 4'd2, 8'h0C, 8'h0A,  64,  0, 8'd0,   1'b1};

    rst = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; in_op = '0;
    launch = 1'b0; finish = 1'b0; third_largest = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_flags", 32'({start, valid, res_valid, res_err}), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_res_data", 32'(res_data), 32'(0));
    check("rst_data", 32'({data_A, data_B, instruction}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    launch = 1'b1;
    tick();
    launch = 1'b0;
    check("empty_launch_busy", 32'(busy), 32'(0));
    check("empty_launch_start", 32'(start), 32'(0));

    finish = 1'b1; third_largest = 8'h55;
    tick();
    finish = 1'b0; third_largest = 8'h00;
    check("idle_finish_ignored", 32'({busy, res_valid}), 32'(0));

    for (int v = 0; v < 5; v++) begin
      push_seq(vecs[v].n, vecs[v].op, vecs[v].a0, vecs[v].b);
      run_job(vecs[v].fin_delay, vecs[v].rdy_delay, 0, 1'b0, r_res, r_err, r_cnt);
      check("vec_count", 32'(r_cnt), 32'(vecs[v].n));
      check("vec_res_data", 32'(r_res), 32'(vecs[v].exp_res));
      check("vec_res_err", 32'(r_err), 32'(vecs[v].exp_err));
    end

    // Late pushes stay queued; launch held through a 10-cycle RESULT is ignored.
    push_seq(3, 4'd0, 8'd7, 8'd1);
    run_job(2, 10, 2, 1'b0, r_res, r_err, r_cnt);
    check("late_push_count", 32'(r_cnt), 32'(3));
    check("late_push_level", 32'(fifo_level), 32'(2));
    run_job(1, 0, 0, 1'b0, r_res, r_err, r_cnt);
    check("second_job_count", 32'(r_cnt), 32'(2));

    // Fill to DEPTH with in_valid held; the 17th offer must be refused.
    for (int i = 0; i < DEPTH + 1; i++) begin
      in_valid = 1'b1; in_A = 8'(i); in_B = 8'h01; in_op = 4'd3;
      if (i == DEPTH) check("full_in_ready_low", 32'(in_ready), 32'(0));
      tick();
    end
    in_valid = 1'b0;
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    run_job(10, 0, 0, 1'b0, r_res, r_err, r_cnt);
    check("full_job_count", 32'(r_cnt), 32'(DEPTH));

    for (int j = 0; j < 15; j++) begin
      int tgt;
      tgt = $urandom_range(1, DEPTH);
      for (int c = 0; c < 200 && model_q.size() < tgt; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_A     = 8'($urandom);
        in_B     = 8'($urandom);
        in_op    = 4'($urandom_range(0, 7));
        tick();
      end
      in_valid = 1'b0;
      run_job($urandom_range(0, 70), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1,
              r_res, r_err, r_cnt);
    end

    // Reset during STREAM beat 2 of 8 discards everything immediately.
    push_seq(8, 4'd0, 8'd1, 8'd10);
    launch = 1'b1;
    tick();
    launch = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      entry_t e;
      e = model_q.pop_front();
      check("pre_rst_beat_A", 32'(data_A), 32'(e.a));
      if (i == 0) tick();
    end
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(valid), 32'(0));
    check("mid_rst_level", 32'(fifo_level), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    model_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < TIMEOUT + 16; c++) begin
      finish        = ($urandom_range(0, 7) == 0);
      third_largest = 8'($urandom);
      tick();
      check("post_rst_no_result", 32'({busy, res_valid}), 32'(0));
    end
    finish = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
